// File: rtl/spdif_pkg.sv
// spdif_pkg: shared constants, FSM state type and helpers for the S/PDIF
// stream sequencer.
//   - channel-status (CS) bit indices and block geometry
//   - CRC-8 polynomial / init value and a single-bit CRC step
//   - cs_build(): assembles the 192-bit CS shadow from the cfg_* inputs
package spdif_pkg;

    localparam int CS_COPY    = 2;
    localparam int CS_PREEMPH = 3;
    localparam int CS_CAT     = 8;
    localparam int CS_FS      = 24;
    localparam int CS_WLEN    = 32;
    localparam int CS_CRC     = 184;

    localparam int CS_FRAMES  = 192;
    localparam int SUB_FRAMES = 384;

    localparam logic [7:0] CRC_POLY = 8'h1D;   // x^8+x^4+x^3+x^2+1
    localparam logic [7:0] CRC_INIT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_L = 2'd1,
        SEND_R = 2'd2
    } state_t;

    // One serial CRC step, MSB-first shift register form.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

    // Consumer-format CS vector; bits 0/1 stay 0 (consumer, audio) and every
    // unlisted bit is 0. Field LSBs land on the lowest frame index.
    function automatic logic [CS_FRAMES-1:0] cs_build(
        input logic       copy_permit,
        input logic       pre_emphasis,
        input logic [7:0] category,
        input logic [3:0] fs,
        input logic [3:0] word_length
    );
        logic [CS_FRAMES-1:0] v;
        v                = '0;
        v[CS_COPY]       = copy_permit;
        v[CS_PREEMPH]    = pre_emphasis;
        v[CS_CAT +: 8]   = category;
        v[CS_FS +: 4]    = fs;
        v[CS_WLEN +: 4]  = word_length;
        return v;
    endfunction

endpackage

// File: rtl/spdif_stream_sequencer_if.sv
// spdif_stream_sequencer_if: link between the sequencer and the S/PDIF
// subframe encoder.
//   master (sequencer): drives o_valid, o_is_left, o_audio, o_user, o_control;
//                       receives o_ready and the encoder's sub_frame_number.
//   slave  (encoder)  : the mirror image.
interface spdif_stream_sequencer_if #(
    parameter int audio_width = 24
);
    logic                   o_valid;
    logic                   o_ready;
    logic                   o_is_left;
    logic [audio_width-1:0] o_audio;
    logic                   o_user;
    logic                   o_control;
    logic [8:0]             sub_frame_number;

    modport master (
        output o_valid, o_is_left, o_audio, o_user, o_control,
        input  o_ready, sub_frame_number
    );

    modport slave (
        input  o_valid, o_is_left, o_audio, o_user, o_control,
        output o_ready, sub_frame_number
    );
endinterface

// File: rtl/spdif_stream_sequencer_cs_crc8.sv
// spdif_cs_crc8: serial CRC-8 over the channel-status bit stream.
//   clk128 : bit clock
//   reset  : synchronous, active-high; crc returns to CRC_INIT
//   init   : restart at CRC_INIT; if en is also high the bit is folded into
//            the fresh value, so the first bit of a block is not lost
//   en     : fold bit_in into the CRC this cycle
//   bit_in : channel-status bit being transferred
//   crc    : current CRC value
module spdif_cs_crc8
    import spdif_pkg::*;
(
    input  logic       clk128,
    input  logic       reset,
    input  logic       init,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);
    logic [7:0] base;

    assign base = init ? CRC_INIT : crc;

    always_ff @(posedge clk128) begin
        if (reset)   crc <= CRC_INIT;
        else if (en) crc <= crc8_step(base, bit_in);
        else         crc <= base;
    end
endmodule

// File: rtl/spdif_stream_sequencer.sv
// spdif_stream_sequencer: takes stereo PCM pairs and hands them to the S/PDIF
// subframe encoder as left then right subframes, attaching the C and U bits
// aligned to the encoder's 384-subframe block counter. A right subframe still
// waiting when the encoder counter returns to an even (left) slot is dropped
// and counted, so the next pair starts on the left again.
//
// Ports
//   clk128, reset        : bit clock, synchronous active-high reset
//   i_valid/i_ready      : upstream pair handshake (i_ready registered, IDLE only)
//   i_left, i_right      : PCM samples, audio_width bits
//   cfg_*                : channel-status fields, latched at each block start
//   enc (master modport) : encoder link (o_valid/o_ready/o_is_left/o_audio/
//                          o_user/o_control, sub_frame_number from encoder)
//   block_start          : high during the frame-0 left transfer
//   slip_count           : saturating count of dropped right samples
//
// Build option: define SPDIF_CS_CRC_EN to carry a CRC-8 of CS frames 0..183
// in frames 184..191 (MSB first). Without it those frames are 0.
module spdif_stream_sequencer
    import spdif_pkg::*;
#(
    parameter int audio_width = 24,
    parameter int slip_width  = 8
)(
    input  logic                   clk128,
    input  logic                   reset,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [audio_width-1:0] i_left,
    input  logic [audio_width-1:0] i_right,
    input  logic                   cfg_copy_permit,
    input  logic                   cfg_pre_emphasis,
    input  logic [7:0]             cfg_category,
    input  logic [3:0]             cfg_fs,
    input  logic [3:0]             cfg_word_length,
    spdif_stream_sequencer_if.master enc,
    output logic                   block_start,
    output logic [slip_width-1:0]  slip_count
);
    state_t                 state;
    logic                   valid_q;
    logic                   is_left_q;
    logic [audio_width-1:0] audio_q;
    logic [audio_width-1:0] right_q;
    logic [CS_FRAMES-1:0]   cs_q;

    logic [7:0] frame;
    logic       side_ok;
    logic       xfer;
    logic       cs_bit;
    logic       c_bit;

    assign frame   = enc.sub_frame_number[8:1];
    // The encoder ignores a subframe offered on the wrong side, so a
    // handshake only counts when the side matches its slot parity.
    assign side_ok = (is_left_q == ~enc.sub_frame_number[0]);
    assign xfer    = valid_q & enc.o_ready & side_ok;

    assign block_start = xfer & is_left_q & (enc.sub_frame_number == 9'd0);

    assign cs_bit = (frame < 8'(CS_FRAMES)) ? cs_q[frame] : 1'b0;

`ifdef SPDIF_CS_CRC_EN
    logic [7:0] crc;
    logic       in_crc;

    assign in_crc = (frame >= 8'(CS_CRC));

    // Only left transfers feed the CRC, so a dropped right never disturbs it.
    spdif_cs_crc8 u_cs_crc8 (
        .clk128 (clk128),
        .reset  (reset),
        .init   (block_start),
        .en     (xfer & is_left_q & ~in_crc),
        .bit_in (cs_bit),
        .crc    (crc)
    );

    // Frames 184..191 have frame[2:0] = 0..7; send the CRC MSB first.
    assign c_bit = in_crc ? crc[3'd7 - frame[2:0]] : cs_bit;
`else
    assign c_bit = cs_bit;
`endif

    assign enc.o_valid   = valid_q;
    assign enc.o_is_left = is_left_q;
    assign enc.o_audio   = audio_q;
    assign enc.o_user    = 1'b0;
    assign enc.o_control = valid_q & c_bit;

    always_ff @(posedge clk128) begin
        if (reset) begin
            state      <= IDLE;
            i_ready    <= 1'b0;
            valid_q    <= 1'b0;
            is_left_q  <= 1'b1;
            audio_q    <= '0;
            right_q    <= '0;
            slip_count <= '0;
            cs_q       <= '0;
        end else begin
            // Shadow reload keeps the CS stream constant for a whole block.
            if (block_start)
                cs_q <= cs_build(cfg_copy_permit, cfg_pre_emphasis, cfg_category,
                                 cfg_fs, cfg_word_length);

            case (state)
                IDLE: begin
                    if (i_ready && i_valid) begin
                        audio_q   <= i_left;
                        right_q   <= i_right;
                        valid_q   <= 1'b1;
                        is_left_q <= 1'b1;
                        i_ready   <= 1'b0;
                        state     <= SEND_L;
                    end else begin
                        i_ready   <= 1'b1;
                    end
                end
                SEND_L: begin
                    if (xfer) begin
                        is_left_q <= 1'b0;
                        audio_q   <= right_q;
                        state     <= SEND_R;
                    end
                end
                SEND_R: begin
                    // An even slot here means the encoder restarted its count
                    // (underrun): give up on the right sample to realign.
                    if (xfer || !enc.sub_frame_number[0]) begin
                        valid_q   <= 1'b0;
                        is_left_q <= 1'b1;
                        i_ready   <= 1'b1;
                        state     <= IDLE;
                        if (!xfer && (slip_count != {slip_width{1'b1}}))
                            slip_count <= slip_count + 1'b1;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    i_ready <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spdif_stream_sequencer.sv
// Directed bench for spdif_stream_sequencer with a simple encoder model whose
// sub_frame_number advances on every accepted subframe and can be forced.
module tb_spdif_stream_sequencer;
    logic        clk128 = 1'b0;
    logic        reset  = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [23:0] i_left  = '0;
    logic [23:0] i_right = '0;
    logic        cfg_copy_permit  = 1'b0;
    logic        cfg_pre_emphasis = 1'b0;
    logic [7:0]  cfg_category     = '0;
    logic [3:0]  cfg_fs           = '0;
    logic [3:0]  cfg_word_length  = '0;
    logic        block_start;
    logic [7:0]  slip_count;

    logic        o_ready_tb = 1'b1;
    logic [8:0]  sfn        = '0;
    logic        sfn_load   = 1'b0;
    logic [8:0]  sfn_val    = '0;

    int n_chk = 0;
    int n_err = 0;

    logic [191:0] cl = '0, cr = '0;
    int           bs_cnt = 0, ord_err = 0;
    logic         last_left = 1'b0;
    logic [24:0]  xq[$];

    spdif_stream_sequencer_if #(.audio_width(24)) enc();

    assign enc.o_ready          = o_ready_tb;
    assign enc.sub_frame_number = sfn;

    spdif_stream_sequencer #(.audio_width(24), .slip_width(8)) dut (
        .clk128           (clk128),
        .reset            (reset),
        .i_valid          (i_valid),
        .i_ready          (i_ready),
        .i_left           (i_left),
        .i_right          (i_right),
        .cfg_copy_permit  (cfg_copy_permit),
        .cfg_pre_emphasis (cfg_pre_emphasis),
        .cfg_category     (cfg_category),
        .cfg_fs           (cfg_fs),
        .cfg_word_length  (cfg_word_length),
        .enc              (enc),
        .block_start      (block_start),
        .slip_count       (slip_count)
    );

    always #5 clk128 = ~clk128;

    // Encoder model: counter advances only on a side-matched transfer.
    always @(posedge clk128) begin
        if (sfn_load)
            sfn <= sfn_val;
        else if (enc.o_valid && enc.o_ready && (enc.o_is_left == ~sfn[0]))
            sfn <= (sfn == 9'd383) ? 9'd0 : sfn + 9'd1;
    end

    // Transfer monitor, sampled away from the active edge.
    always @(negedge clk128) begin
        if (!reset) begin
            if (block_start) bs_cnt++;
            if (enc.o_valid && enc.o_ready && (enc.o_is_left == ~enc.sub_frame_number[0])) begin
                if (enc.o_is_left) begin
                    cl[enc.sub_frame_number[8:1]] = enc.o_control;
                    if (last_left) ord_err++;
                end else begin
                    cr[enc.sub_frame_number[8:1]] = enc.o_control;
                    if (!last_left) ord_err++;
                end
                last_left = enc.o_is_left;
                xq.push_back({enc.o_is_left, enc.o_audio});
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc_model(input logic [191:0] cs);
        logic [7:0] c;
        logic       fb;
        c = 8'hFF;
        for (int i = 0; i < 184; i++) begin
            fb = c[7] ^ cs[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h1D;
        end
        return c;
    endfunction

    // Expected CS stream for a block: CRC or zeros in frames 184..191.
    function automatic logic [191:0] with_tail(input logic [191:0] cs);
        logic [191:0] v;
        logic [7:0]   c;
        v = cs;
        c = crc_model(cs);
`ifdef SPDIF_CS_CRC_EN
        for (int i = 0; i < 8; i++) v[184 + i] = c[7 - i];
`else
        if (c == 8'h00) v[0] = cs[0];   // keeps c referenced; tail stays 0
        v[191:184] = 8'h00;
`endif
        return v;
    endfunction

    task automatic load_sfn(input logic [8:0] v);
        sfn_val  = v;
        sfn_load = 1'b1;
        @(negedge clk128);
        sfn_load = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the pair is accepted.
    task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
        int n;
        n = 0;
        while (!i_ready && n < 50) begin
            @(negedge clk128);
            n++;
        end
        if (!i_ready) chk("send_timeout", 64'(i_ready), 64'd1);
        i_valid = 1'b1;
        i_left  = l;
        i_right = r;
        @(negedge clk128);
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!i_ready && n < 50) begin
            @(negedge clk128);
            n++;
        end
        if (!i_ready) chk("idle_timeout", 64'(i_ready), 64'd1);
    endtask

    task automatic stream(input int n);
        for (int k = 0; k < n; k++) send_pair(24'(k), ~24'(k));
        wait_idle();
    endtask

    task automatic chk_cs(input string tag, input logic [191:0] got, input logic [191:0] exp);
        chk({tag, "_lo"},  got[63:0],    exp[63:0]);
        chk({tag, "_mid"}, got[127:64],  exp[127:64]);
        chk({tag, "_hi"},  got[191:128], exp[191:128]);
    endtask

    initial begin
        logic [191:0] exp2, exp6;
        int bs0, ord0, q0, low;

        // Reset state
        repeat (2) @(negedge clk128);
        chk("rst_i_ready",   64'(i_ready),       64'd0);
        chk("rst_o_valid",   64'(enc.o_valid),   64'd0);
        chk("rst_o_is_left", 64'(enc.o_is_left), 64'd1);
        chk("rst_o_audio",   64'(enc.o_audio),   64'd0);
        chk("rst_o_control", 64'(enc.o_control), 64'd0);
        chk("rst_blk_start", 64'(block_start),   64'd0);
        chk("rst_slip",      64'(slip_count),    64'd0);
        reset = 1'b0;
        @(negedge clk128);
        chk("idle_ready", 64'(i_ready), 64'd1);

        // Test 1: single pair, order and i_ready span
        q0 = xq.size();
        i_valid = 1'b1; i_left = 24'h123456; i_right = 24'hABCDEF;
        @(negedge clk128);
        i_valid = 1'b0;
        chk("t1_first_out", 64'({enc.o_valid, enc.o_is_left, enc.o_audio}), 64'({2'b11, 24'h123456}));
        chk("t1_user", 64'(enc.o_user), 64'd0);
        low = 0;
        while (!i_ready && low < 20) begin
            low++;
            @(negedge clk128);
        end
        chk("t1_ready_low", 64'(low), 64'd2);
        chk("t1_xfer_l", 64'(xq[q0]),     64'({1'b1, 24'h123456}));
        chk("t1_xfer_r", 64'(xq[q0 + 1]), 64'({1'b0, 24'hABCDEF}));

        // Test 2: one full block with copy/category/fs set
        cfg_copy_permit = 1'b1; cfg_category = 8'h01; cfg_fs = 4'h2;
        load_sfn(9'd0);
        bs0 = bs_cnt; ord0 = ord_err;
        stream(192);
        exp2 = '0;
        exp2[2] = 1'b1; exp2[8] = 1'b1; exp2[25] = 1'b1;
        exp2 = with_tail(exp2);
        chk_cs("t2_cs_left",  cl, exp2);
        chk_cs("t2_cs_right", cr, exp2);
        chk("t2_blk_starts", 64'(bs_cnt - bs0), 64'd1);

        // Test 3: cfg_fs change mid-block only takes effect at the next block
        bs0 = bs_cnt;
        stream(96);
        cfg_fs = 4'hF;
        stream(96);
        chk_cs("t3_cs_held", cl, exp2);
        stream(30);
        chk("t3_fs_new", 64'(cl[27:24]), 64'hF);
        chk("t3_blk_starts", 64'(bs_cnt - bs0), 64'd2);
        chk("t3_order", 64'(ord_err - ord0), 64'd0);

        // Test 4: forced underrun while the right subframe waits
        for (int i = 0; i < 300; i++) begin
            send_pair(24'h0A0000 + 24'(i), 24'h0B0000 + 24'(i));
            if (i == 1)
                chk("t4_left_after_slip",
                    64'({enc.o_valid, enc.o_is_left, sfn[0], enc.o_audio}),
                    64'({3'b110, 24'h0A0001}));
            @(negedge clk128);
            o_ready_tb = 1'b0;
            sfn_val = 9'd0; sfn_load = 1'b1;
            @(negedge clk128);
            sfn_load = 1'b0;
            @(negedge clk128);
            o_ready_tb = 1'b1;
            if (i == 0) begin
                chk("t4_slip_one",   64'(slip_count),  64'd1);
                chk("t4_dropped",    64'(enc.o_valid), 64'd0);
                chk("t4_ready_back", 64'(i_ready),     64'd1);
            end
            if (i == 253) chk("t4_slip_254", 64'(slip_count), 64'd254);
            if (i == 255) chk("t4_slip_sat", 64'(slip_count), 64'd255);
        end
        chk("t4_slip_300", 64'(slip_count), 64'd255);

        // Test 5: reset while holding a left subframe
        o_ready_tb = 1'b0;
        send_pair(24'h111111, 24'h222222);
        chk("t5_in_send_l", 64'({enc.o_valid, enc.o_is_left}), 64'b11);
        reset = 1'b1;
        @(negedge clk128);
        reset = 1'b0;
        chk("t5_o_valid", 64'(enc.o_valid), 64'd0);
        chk("t5_i_ready", 64'(i_ready),     64'd0);
        chk("t5_slip",    64'(slip_count),  64'd0);
        @(negedge clk128);
        chk("t5_idle_ready", 64'(i_ready), 64'd1);
        o_ready_tb = 1'b1;

        // Test 6: all-zero config, tail carries CRC of 184 zeros (or zeros)
        cfg_copy_permit = 1'b0; cfg_category = 8'h00; cfg_fs = 4'h0;
        load_sfn(9'd0);
        stream(192);
        exp6 = with_tail('0);
        chk_cs("t6_cs_zero_cfg", cl, exp6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
